// File: rtl/vga_mainmenu_controller_pkg.sv
// Shared definitions for the main-menu cursor controller: option codes,
// FSM states, the metadata field position and the grid navigation rule.
package tetris_menu_pkg;

  localparam logic [2:0] OPT_PLAY1P  = 3'd0;
  localparam logic [2:0] OPT_ENDLESS = 3'd1;
  localparam logic [2:0] OPT_PLAY2P  = 3'd2;
  localparam logic [2:0] OPT_TOP1P   = 3'd3;
  localparam logic [2:0] OPT_TOPEND  = 3'd4;

  localparam int MENU_SEL_LSB = 26;

  typedef enum logic [1:0] {
    MENU    = 2'd0,
    LAUNCH  = 2'd1,
    PLAYING = 2'd2
  } menu_state_e;

  typedef enum logic [1:0] {
    NAV_UP    = 2'd0,
    NAV_DOWN  = 2'd1,
    NAV_LEFT  = 2'd2,
    NAV_RIGHT = 2'd3
  } nav_dir_e;

  // Saturating moves on the 3+2 option grid; anything not listed stays put.
  function automatic logic [2:0] nav_step(input logic [2:0] sel, input nav_dir_e dir);
    logic [2:0] nxt;
    nxt = sel;
    case (dir)
      NAV_UP: begin
        case (sel)
          OPT_ENDLESS: nxt = OPT_PLAY1P;
          OPT_PLAY2P:  nxt = OPT_ENDLESS;
          OPT_TOPEND:  nxt = OPT_TOP1P;
          default:     nxt = sel;
        endcase
      end
      NAV_DOWN: begin
        case (sel)
          OPT_PLAY1P:  nxt = OPT_ENDLESS;
          OPT_ENDLESS: nxt = OPT_PLAY2P;
          OPT_TOP1P:   nxt = OPT_TOPEND;
          default:     nxt = sel;
        endcase
      end
      NAV_LEFT: begin
        case (sel)
          OPT_TOP1P:  nxt = OPT_PLAY1P;
          OPT_TOPEND: nxt = OPT_ENDLESS;
          default:    nxt = sel;
        endcase
      end
      NAV_RIGHT: begin
        case (sel)
          OPT_PLAY1P:  nxt = OPT_TOP1P;
          OPT_ENDLESS: nxt = OPT_TOPEND;
          OPT_PLAY2P:  nxt = OPT_TOPEND;
          default:     nxt = sel;
        endcase
      end
      default: nxt = sel;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/vga_mainmenu_controller_if.sv
// Button inputs, game-core start handshake and cursor outputs of the menu controller.
interface vga_mainmenu_controller_if;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic       btn_select;
  logic       game_over;
  logic       start_ready;
  logic [2:0] menu_sel;
  logic       in_menu;
  logic       start_valid;
  logic [2:0] start_mode;

  modport master (
    input  btn_up, btn_down, btn_left, btn_right, btn_select, game_over, start_ready,
    output menu_sel, in_menu, start_valid, start_mode
  );

  modport slave (
    output btn_up, btn_down, btn_left, btn_right, btn_select, game_over, start_ready,
    input  menu_sel, in_menu, start_valid, start_mode
  );
endinterface

// File: rtl/vga_mainmenu_controller_button_debouncer.sv
// Two-flop synchroniser, hold-time debouncer and single-cycle press pulse
// for one asynchronous active-high button.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned CNT_W           = 18
) (
  input  logic clock,
  input  logic resetn,
  input  logic raw,
  output logic press
);

  logic             sync_meta;
  logic             sync_out;
  logic             stable;
  logic             stable_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync_meta <= 1'b0;
      sync_out  <= 1'b0;
    end else begin
      sync_meta <= raw;
      sync_out  <= sync_meta;
    end
  end

  // A new level is accepted only after it has differed from stable for DEBOUNCE_CYCLES edges.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stable <= 1'b0;
      cnt    <= '0;
    end else if (sync_out != stable) begin
      if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable <= sync_out;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end else begin
      cnt <= '0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stable_d <= 1'b0;
      press    <= 1'b0;
    end else begin
      stable_d <= stable;
      press    <= stable & ~stable_d;
    end
  end

endmodule

// File: rtl/vga_mainmenu_controller.sv
// Main-menu cursor controller: debounces five buttons, moves the selection
// cursor over the option grid and launches the chosen mode via valid/ready.
module vga_mainmenu_controller
  import tetris_menu_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned CNT_W           = 18
) (
  input  logic                        clock,
  input  logic                        resetn,
  vga_mainmenu_controller_if.master   bus
);

  logic        press_up;
  logic        press_down;
  logic        press_left;
  logic        press_right;
  logic        press_select;

  menu_state_e state;
  logic [2:0]  menu_sel;
  logic        in_menu;
  logic        start_valid;
  logic [2:0]  start_mode;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_up (
    .clock(clock), .resetn(resetn), .raw(bus.btn_up), .press(press_up)
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_down (
    .clock(clock), .resetn(resetn), .raw(bus.btn_down), .press(press_down)
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_left (
    .clock(clock), .resetn(resetn), .raw(bus.btn_left), .press(press_left)
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_right (
    .clock(clock), .resetn(resetn), .raw(bus.btn_right), .press(press_right)
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_select (
    .clock(clock), .resetn(resetn), .raw(bus.btn_select), .press(press_select)
  );

  // One action per cycle: Select beats Up beats Down beats Left beats Right.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= MENU;
      menu_sel    <= OPT_PLAY1P;
      in_menu     <= 1'b1;
      start_valid <= 1'b0;
      start_mode  <= OPT_PLAY1P;
    end else begin
      case (state)
        MENU: begin
          if (press_select) begin
            start_mode  <= menu_sel;
            start_valid <= 1'b1;
            in_menu     <= 1'b0;
            state       <= LAUNCH;
          end else if (press_up) begin
            menu_sel <= nav_step(menu_sel, NAV_UP);
          end else if (press_down) begin
            menu_sel <= nav_step(menu_sel, NAV_DOWN);
          end else if (press_left) begin
            menu_sel <= nav_step(menu_sel, NAV_LEFT);
          end else if (press_right) begin
            menu_sel <= nav_step(menu_sel, NAV_RIGHT);
          end
        end
        LAUNCH: begin
          if (bus.start_ready) begin
            start_valid <= 1'b0;
            state       <= PLAYING;
          end
        end
        PLAYING: begin
          if (bus.game_over) begin
            in_menu <= 1'b1;
            state   <= MENU;
          end
        end
        default: begin
          state       <= MENU;
          in_menu     <= 1'b1;
          start_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.menu_sel    = menu_sel;
  assign bus.in_menu     = in_menu;
  assign bus.start_valid = start_valid;
  assign bus.start_mode  = start_mode;

endmodule

// File: tb/tb_vga_mainmenu_controller.sv
// Self-checking bench for vga_mainmenu_controller with DEBOUNCE_CYCLES=4,
// using an event-level grid model of cursor movement.
module tb_vga_mainmenu_controller;

  logic clock = 1'b0;
  logic resetn;
  int   checks = 0;
  int   fails  = 0;
  int   model_sel = 0;

  always #5 clock = ~clock;

  vga_mainmenu_controller_if bus ();

  vga_mainmenu_controller #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus)
  );

  // Cursor position as (column,row): left column has 3 rows, right column 2.
  function automatic int grid_move(int sel, int dir);
    int col;
    int row;
    col = (sel >= 3) ? 1 : 0;
    row = col ? sel - 3 : sel;
    case (dir)
      0: row = (row > 0) ? row - 1 : 0;
      1: row = (row < (col ? 1 : 2)) ? row + 1 : row;
      2: col = 0;
      3: begin
        if (col == 0) begin
          col = 1;
          if (row > 1) row = 1;
        end
      end
      default: ;
    endcase
    return col ? 3 + row : row;
  endfunction

  task automatic step(int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic set_btn(int dir, logic v);
    case (dir)
      0: bus.btn_up     = v;
      1: bus.btn_down   = v;
      2: bus.btn_left   = v;
      3: bus.btn_right  = v;
      default: bus.btn_select = v;
    endcase
  endtask

  task automatic press(int dir, int len);
    set_btn(dir, 1'b1);
    step(len);
    set_btn(dir, 1'b0);
    step(10);
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    step(2);
    resetn = 1'b1;
    step(2);
    model_sel = 0;
  endtask

  always @(negedge clock) begin
    if (resetn === 1'b1) begin
      checks++;
      if (!(bus.menu_sel <= 3'd4)) begin
        fails++;
        $display("[TB] FAIL menu_sel_range: got %0d, need <= 4", bus.menu_sel);
      end
    end
  end

  task automatic test_reset();
    resetn = 1'b0;
    step(2);
    checks++;
    if ({bus.menu_sel, bus.in_menu, bus.start_valid, bus.start_mode} !== {3'd0, 1'b1, 1'b0, 3'd0}) begin
      fails++;
      $display("[TB] FAIL reset_outputs: sel=%0d in_menu=%b valid=%b mode=%0d, need 0 1 0 0",
               bus.menu_sel, bus.in_menu, bus.start_valid, bus.start_mode);
    end
    resetn = 1'b1;
    step(3);
    checks++;
    if ({bus.menu_sel, bus.in_menu, bus.start_valid} !== {3'd0, 1'b1, 1'b0}) begin
      fails++;
      $display("[TB] FAIL post_reset_idle: sel=%0d in_menu=%b valid=%b, need 0 1 0",
               bus.menu_sel, bus.in_menu, bus.start_valid);
    end
    model_sel = 0;
  endtask

  task automatic test_press_latency();
    int changes = 0;
    int change_edge = -1;
    logic [2:0] prev;
    apply_reset();
    prev = bus.menu_sel;
    set_btn(1, 1'b1);
    for (int e = 1; e <= 14; e++) begin
      step(1);
      if (bus.menu_sel !== prev) begin
        changes++;
        if (change_edge < 0) change_edge = e;
        prev = bus.menu_sel;
      end
    end
    set_btn(1, 1'b0);
    step(10);
    model_sel = grid_move(model_sel, 1);
    checks++;
    if (changes != 1) begin
      fails++;
      $display("[TB] FAIL hold_single_change: got %0d changes, need 1", changes);
    end
    checks++;
    if (change_edge != 8) begin
      fails++;
      $display("[TB] FAIL press_latency: change at edge %0d, need 8", change_edge);
    end
    checks++;
    if (bus.menu_sel !== 3'(model_sel)) begin
      fails++;
      $display("[TB] FAIL hold_down_sel: got %0d, need %0d", bus.menu_sel, model_sel);
    end
  endtask

  task automatic test_glitch();
    apply_reset();
    press(3, 3);
    checks++;
    if (bus.menu_sel !== 3'(model_sel)) begin
      fails++;
      $display("[TB] FAIL glitch_rejected: got %0d, need %0d", bus.menu_sel, model_sel);
    end
    press(3, 5);
    model_sel = grid_move(model_sel, 3);
    checks++;
    if (bus.menu_sel !== 3'(model_sel)) begin
      fails++;
      $display("[TB] FAIL long_right_press: got %0d, need %0d", bus.menu_sel, model_sel);
    end
  endtask

  task automatic test_navigation();
    int seq[7] = '{0, 2, 1, 1, 1, 3, 3};
    apply_reset();
    foreach (seq[i]) begin
      press(seq[i], 6);
      model_sel = grid_move(model_sel, seq[i]);
      checks++;
      if (bus.menu_sel !== 3'(model_sel)) begin
        fails++;
        $display("[TB] FAIL nav_step%0d dir%0d: got %0d, need %0d", i, seq[i], bus.menu_sel, model_sel);
      end
    end
  endtask

  task automatic test_random_nav();
    for (int i = 0; i < 16; i++) begin
      int dir;
      int is_long;
      int len;
      dir = int'($urandom_range(0, 3));
      is_long = int'($urandom_range(0, 1));
      len = is_long ? int'($urandom_range(5, 9)) : int'($urandom_range(1, 3));
      press(dir, len);
      if (is_long) model_sel = grid_move(model_sel, dir);
      checks++;
      if (bus.menu_sel !== 3'(model_sel) || bus.in_menu !== 1'b1) begin
        fails++;
        $display("[TB] FAIL random_nav%0d dir%0d len%0d: sel=%0d in_menu=%b, need %0d 1",
                 i, dir, len, bus.menu_sel, bus.in_menu, model_sel);
      end
    end
  endtask

  task automatic test_select_priority();
    bit seen = 0;
    apply_reset();
    press(1, 6);
    model_sel = grid_move(model_sel, 1);
    set_btn(0, 1'b1);
    set_btn(4, 1'b1);
    for (int i = 0; i < 20 && !seen; i++) begin
      step(1);
      if (bus.start_valid === 1'b1) seen = 1;
    end
    set_btn(0, 1'b0);
    set_btn(4, 1'b0);
    checks++;
    if (!seen || bus.start_mode !== 3'(model_sel) || bus.menu_sel !== 3'(model_sel) || bus.in_menu !== 1'b0) begin
      fails++;
      $display("[TB] FAIL select_priority: valid_seen=%0d mode=%0d sel=%0d in_menu=%b, need 1 %0d %0d 0",
               seen, bus.start_mode, bus.menu_sel, bus.in_menu, model_sel, model_sel);
    end
    step(10);
    bus.start_ready = 1'b1;
    step(1);
    bus.start_ready = 1'b0;
    bus.game_over = 1'b1;
    step(1);
    bus.game_over = 1'b0;
    step(1);
    checks++;
    if (bus.in_menu !== 1'b1 || bus.menu_sel !== 3'(model_sel)) begin
      fails++;
      $display("[TB] FAIL priority_return: in_menu=%b sel=%0d, need 1 %0d", bus.in_menu, bus.menu_sel, model_sel);
    end
  endtask

  task automatic test_launch_hold();
    int bad = 0;
    apply_reset();
    press(3, 6);
    model_sel = grid_move(model_sel, 3);
    press(1, 6);
    model_sel = grid_move(model_sel, 1);
    bus.game_over = 1'b1;
    step(1);
    bus.game_over = 1'b0;
    step(1);
    checks++;
    if (bus.in_menu !== 1'b1 || bus.start_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL game_over_in_menu: in_menu=%b valid=%b, need 1 0", bus.in_menu, bus.start_valid);
    end
    set_btn(4, 1'b1);
    step(7);
    checks++;
    if (bus.start_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL select_early: valid=%b at edge 7, need 0", bus.start_valid);
    end
    step(1);
    checks++;
    if (bus.start_valid !== 1'b1 || bus.in_menu !== 1'b0 || bus.start_mode !== 3'(model_sel)) begin
      fails++;
      $display("[TB] FAIL select_launch: valid=%b in_menu=%b mode=%0d, need 1 0 %0d",
               bus.start_valid, bus.in_menu, bus.start_mode, model_sel);
    end
    set_btn(4, 1'b0);
    set_btn(0, 1'b1);
    for (int c = 0; c < 16; c++) begin
      if (c == 6) set_btn(0, 1'b0);
      if (c == 8) set_btn(2, 1'b1);
      if (c == 14) set_btn(2, 1'b0);
      step(1);
      if (bus.start_valid !== 1'b1 || bus.start_mode !== 3'(model_sel)) bad++;
    end
    step(8);
    checks++;
    if (bad != 0) begin
      fails++;
      $display("[TB] FAIL launch_stable: %0d unstable cycles, need 0", bad);
    end
    checks++;
    if (bus.menu_sel !== 3'(model_sel) || bus.in_menu !== 1'b0) begin
      fails++;
      $display("[TB] FAIL launch_ignores_nav: sel=%0d in_menu=%b, need %0d 0", bus.menu_sel, bus.in_menu, model_sel);
    end
    bus.start_ready = 1'b1;
    step(1);
    bus.start_ready = 1'b0;
    checks++;
    if (bus.start_valid !== 1'b0 || bus.in_menu !== 1'b0) begin
      fails++;
      $display("[TB] FAIL handshake_accept: valid=%b in_menu=%b, need 0 0", bus.start_valid, bus.in_menu);
    end
    press(1, 6);
    press(4, 6);
    checks++;
    if (bus.menu_sel !== 3'(model_sel) || bus.in_menu !== 1'b0 || bus.start_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL playing_ignores_btn: sel=%0d in_menu=%b valid=%b, need %0d 0 0",
               bus.menu_sel, bus.in_menu, bus.start_valid, model_sel);
    end
    bus.game_over = 1'b1;
    step(1);
    bus.game_over = 1'b0;
    checks++;
    if (bus.in_menu !== 1'b1 || bus.menu_sel !== 3'(model_sel)) begin
      fails++;
      $display("[TB] FAIL game_over_return: in_menu=%b sel=%0d, need 1 %0d", bus.in_menu, bus.menu_sel, model_sel);
    end
  endtask

  task automatic test_reset_in_launch();
    bit seen = 0;
    set_btn(4, 1'b1);
    for (int i = 0; i < 20 && !seen; i++) begin
      step(1);
      if (bus.start_valid === 1'b1) seen = 1;
    end
    set_btn(4, 1'b0);
    step(10);
    checks++;
    if (!seen || bus.start_valid !== 1'b1) begin
      fails++;
      $display("[TB] FAIL relaunch: valid=%b, need 1", bus.start_valid);
    end
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (bus.start_valid !== 1'b0 || bus.in_menu !== 1'b1) begin
      fails++;
      $display("[TB] FAIL async_reset: valid=%b in_menu=%b, need 0 1", bus.start_valid, bus.in_menu);
    end
    step(1);
    resetn = 1'b1;
    step(3);
    model_sel = 0;
    checks++;
    if (bus.menu_sel !== 3'(model_sel) || bus.start_valid !== 1'b0 || bus.in_menu !== 1'b1) begin
      fails++;
      $display("[TB] FAIL after_launch_reset: sel=%0d valid=%b in_menu=%b, need 0 0 1",
               bus.menu_sel, bus.start_valid, bus.in_menu);
    end
  endtask

  initial begin
    resetn          = 1'b0;
    bus.btn_up      = 1'b0;
    bus.btn_down    = 1'b0;
    bus.btn_left    = 1'b0;
    bus.btn_right   = 1'b0;
    bus.btn_select  = 1'b0;
    bus.game_over   = 1'b0;
    bus.start_ready = 1'b0;
    test_reset();
    test_press_latency();
    test_glitch();
    test_navigation();
    test_random_nav();
    test_select_priority();
    test_launch_hold();
    test_reset_in_launch();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/vga_mainmenu_controller.md
# vga_mainmenu_controller

Main-menu cursor controller, directly upstream of the main-menu VGA processor. It debounces the five menu buttons and moves a selection cursor across the five-option menu grid. It drives the 3-bit selection index that the top level packs into `metadata[28:26]`, which the processor uses to draw the highlight box. On Select it hands the chosen mode to the game core with a valid/ready handshake, then parks until that game ends.

## Interface
- `DEBOUNCE_CYCLES`, default 250000: cycles an input must hold a new level before it is accepted (5 ms at 50 MHz); must be ≥ 2.
- `CNT_W`, default 18: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- `clock` in 1: system clock, single clock domain.
- `resetn` in 1: asynchronous, active-low reset.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`, `btn_select` in 1 each: raw buttons, active-high, asynchronous to `clock`.
- `game_over` in 1: one-cycle pulse from the game core when a game ends.
- `start_ready` in 1: game core accepts the start request.
- `menu_sel` out 3: cursor index, 0–4. Top level maps it to `metadata[28:26]`.
- `in_menu` out 1: high in state MENU. Selects the main-menu display path.
- `start_valid` out 1: start request pending.
- `start_mode` out 3: mode being launched (the `menu_sel` value at Select).

## Operation
- Per button: 2-FF synchroniser, then a debouncer holding `stable` (reset 0) and `cnt` (reset 0).
  - When synced ≠ `stable`: `cnt`++.
  - When synced = `stable`: `cnt` ← 0.
  - When synced ≠ `stable` and `cnt` = DEBOUNCE_CYCLES−1: `stable` ← synced and `cnt` ← 0.
- Press pulse: registered `stable & ~stable_d`, exactly one cycle per accepted press. Holding a button gives no auto-repeat. Releases produce nothing.
- Grid layout:
  - Left column: 0 = Play 1P, 1 = Endless, 2 = Play 2P.
  - Right column: 3 = Top 1P, 4 = Top Endless.
- Navigation saturates; there is no wrap.
  - Up: 1→0, 2→1, 4→3; 0 and 3 unchanged.
  - Down: 0→1, 1→2, 3→4; 2 and 4 unchanged.
  - Right: 0→3, 1→4, 2→4; 3 and 4 unchanged.
  - Left: 3→0, 4→1; 0, 1 and 2 unchanged.
- Same-cycle pulses: only one action per cycle, priority Select > Up > Down > Left > Right. Lower-priority pulses that cycle are discarded.
- FSM states:
  - MENU (reset state): navigation pulses update `menu_sel`. A Select pulse latches `start_mode` ← `menu_sel` and goes to LAUNCH.
  - LAUNCH: `start_valid`=1 and `start_mode` held stable. All button pulses are ignored. Goes to PLAYING on the first edge with `start_ready`=1.
  - PLAYING: all button pulses are ignored. Goes to MENU on `game_over`. `menu_sel` keeps its pre-launch value.
- `game_over` in MENU or LAUNCH: ignored.
- Encodings 5–7 on `menu_sel` are unreachable. Verification asserts `menu_sel` ≤ 4 at all times.

## Timing
- Reset values: `menu_sel`=0, `in_menu`=1, `start_valid`=0, `start_mode`=0, state MENU, all synchroniser, debounce and edge registers 0. Reset takes effect immediately, asynchronously.
- Reset mid-LAUNCH drops `start_valid` without a handshake. Reset mid-PLAYING returns to MENU.
- Press latency, counted in clock edges after the edge that first samples raw high:
  - 2 edges for synchronisation.
  - DEBOUNCE_CYCLES edges until `stable` rises.
  - 1 edge for the press pulse.
  - 1 edge for the `menu_sel` update.
  - Total: DEBOUNCE_CYCLES+4.
- Glitches: a pulse shorter than DEBOUNCE_CYCLES synced cycles produces no press.
- Handshake: `start_valid` rises the edge after the Select pulse. It falls on the edge where `start_valid`&`start_ready` is sampled. `in_menu` falls on that same edge as the FSM moves to LAUNCH.
- `in_menu` rises the edge after `game_over` is sampled in PLAYING.

## Structure
- Shared package `tetris_menu_pkg`:
  - option codes `OPT_PLAY1P`=0, `OPT_ENDLESS`=1, `OPT_PLAY2P`=2, `OPT_TOP1P`=3, `OPT_TOPEND`=4.
  - state encoding MENU/LAUNCH/PLAYING.
  - `MENU_SEL_LSB`=26, the metadata field position.
- One sub-module, `button_debouncer`: synchroniser, debounce counter and edge pulse. Parameters DEBOUNCE_CYCLES and CNT_W; ports `clock`, `resetn`, `raw`, `press`. Instantiated five times.
- The FSM and navigation logic live in the top module.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Reset, then hold `btn_down` high for 10 cycles → exactly one `menu_sel` change 0→1, occurring 8 edges after the first sample. No further change while held.
- `btn_right` pulsed high for 3 cycles → no press, `menu_sel` unchanged. A 5-cycle pulse → `menu_sel` 0→3.
- From 0: Up, Left, then Down ×3 → 0, 0, 1, 2, 2. Then Right → 4. Then Right → 4.
- Debounced Up and Select pulse on the same cycle with `menu_sel`=1 → LAUNCH with `start_mode`=1 and `menu_sel` still 1.
- Select with `menu_sel`=4 and `start_ready` low for 5 cycles → `start_valid` and `start_mode`=4 held stable. Navigation presses are ignored. `start_ready` high → PLAYING, `in_menu`=0. `game_over` → MENU, `menu_sel`=4.
- `resetn` low for one cycle during LAUNCH → `start_valid`=0 and `in_menu`=1 immediately. `menu_sel`=0 after release.
